// File: rtl/stdp_weight_update.sv
// One synaptic weight with saturating STDP potentiation/depression steps,
// a refractory window after each update, and a saturating coincidence counter.
module stdp_weight_update #(
  parameter int W       = 8,
  parameter int W_INIT  = 128,
  parameter int W_MAX   = 255,
  parameter int W_MIN   = 0,
  parameter int STEP_UP = 4,
  parameter int STEP_DN = 4,
  parameter int REFRACT = 3,
  parameter int CW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          incr,
  input  logic          decr,
  input  logic          sim,
  output logic [W-1:0]  weight,
  output logic          upd,
  output logic          sat_hi,
  output logic          sat_lo,
  output logic          busy,
  output logic [CW-1:0] sim_cnt
);

  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  localparam logic [W:0] UP_K  = (W+1)'(STEP_UP);
  localparam logic [W:0] MAX_K = (W+1)'(W_MAX);
  localparam logic [W:0] DN_TH = (W+1)'(W_MIN + STEP_DN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_REFRACT
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          incr_q;
  logic          decr_q;
  logic          dir;
  logic [RW-1:0] ref_cnt;
  logic          up_ev;
  logic          dn_ev;
  logic          one_ev;
  logic [W:0]    up_sum;
  logic [W-1:0]  w_next;

  // Rising edges only; simultaneous up and down cancel each other out.
  assign up_ev  = incr & ~incr_q;
  assign dn_ev  = decr & ~decr_q;
  assign one_ev = up_ev ^ dn_ev;

  assign sat_hi = (weight == W'(W_MAX));
  assign sat_lo = (weight == W'(W_MIN));
  assign busy   = (state_q != S_IDLE);

  always_comb begin
    up_sum = {1'b0, weight} + UP_K;
    w_next = weight;
    if (dir) begin
      w_next = (up_sum > MAX_K) ? W'(W_MAX) : up_sum[W-1:0];
    end else begin
      w_next = ({1'b0, weight} < DN_TH) ? W'(W_MIN) : (weight - W'(STEP_DN));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (one_ev) state_d = S_APPLY;
      S_APPLY:   state_d = (REFRACT > 0) ? S_REFRACT : S_IDLE;
      S_REFRACT: if (ref_cnt <= RW'(1)) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      weight  <= W'(W_INIT);
      upd     <= 1'b0;
      incr_q  <= 1'b0;
      decr_q  <= 1'b0;
      dir     <= 1'b0;
      ref_cnt <= '0;
      sim_cnt <= '0;
    end else begin
      incr_q <= incr;
      decr_q <= decr;
      upd    <= 1'b0;
      if (state_q == S_IDLE && one_ev) begin
        dir <= up_ev;
      end
      // upd pulses even when the clamp leaves the weight unchanged.
      if (state_q == S_APPLY) begin
        weight  <= w_next;
        upd     <= 1'b1;
        ref_cnt <= RW'(REFRACT);
      end else if (state_q == S_REFRACT) begin
        ref_cnt <= ref_cnt - RW'(1);
      end
      if (sim && (sim_cnt != {CW{1'b1}})) begin
        sim_cnt <= sim_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_stdp_weight_update.sv
// Directed bench for stdp_weight_update with default parameters
// (W=8, W_INIT=128, steps of 4, REFRACT=3, CW=8).
module tb_stdp_weight_update;

  logic       clk;
  logic       rst;
  logic       incr;
  logic       decr;
  logic       sim;
  logic [7:0] weight;
  logic       upd;
  logic       sat_hi;
  logic       sat_lo;
  logic       busy;
  logic [7:0] sim_cnt;

  int total;
  int bad;
  int upd_seen;
  logic [7:0] last_w;
  logic       last_upd;

  stdp_weight_update dut (
    .clk     (clk),
    .rst     (rst),
    .incr    (incr),
    .decr    (decr),
    .sim     (sim),
    .weight  (weight),
    .upd     (upd),
    .sat_hi  (sat_hi),
    .sat_lo  (sat_lo),
    .busy    (busy),
    .sim_cnt (sim_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One isolated event: edge k, result after k+1, wait out refractory, release.
  task automatic pulse(input logic up);
    if (up) incr = 1'b1;
    else    decr = 1'b1;
    step();
    step();
    last_w   = weight;
    last_upd = upd;
    repeat (3) step();
    incr = 1'b0;
    decr = 1'b0;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    incr  = 1'b0;
    decr  = 1'b0;
    sim   = 1'b0;

    // Reset
    step();
    step();
    rst = 1'b0;
    check("rst_weight", weight, 128);
    check("rst_upd", upd, 0);
    check("rst_busy", busy, 0);
    check("rst_sim_cnt", sim_cnt, 0);
    check("rst_sat_hi", sat_hi, 0);
    check("rst_sat_lo", sat_lo, 0);

    // Single potentiation and timing of the busy window
    incr = 1'b1;
    step();
    check("k_busy", busy, 1);
    check("k_upd", upd, 0);
    check("k_weight", weight, 128);
    step();
    check("k1_weight", weight, 132);
    check("k1_upd", upd, 1);
    check("k1_busy", busy, 1);
    step();
    check("k2_upd", upd, 0);
    check("k2_busy", busy, 1);
    step();
    check("k3_busy", busy, 1);
    step();
    check("k4_busy", busy, 0);
    upd_seen = 0;
    repeat (20) begin
      step();
      if (upd) upd_seen++;
    end
    check("hold_weight", weight, 132);
    check("hold_no_upd", upd_seen, 0);
    incr = 1'b0;
    step();

    // Climb to the upper clamp
    repeat (30) pulse(1'b1);
    check("pre_weight", weight, 252);
    check("pre_sat_hi", sat_hi, 0);
    pulse(1'b1);
    check("top_weight", last_w, 255);
    check("top_upd", last_upd, 1);
    check("top_sat_hi", sat_hi, 1);
    pulse(1'b1);
    check("clamp_hi_weight", last_w, 255);
    check("clamp_hi_upd", last_upd, 1);

    // Descend to the lower clamp: 255 - 63*4 = 3
    repeat (63) pulse(1'b0);
    check("low3_weight", weight, 3);
    check("low3_sat_lo", sat_lo, 0);
    pulse(1'b0);
    check("bot_weight", last_w, 0);
    check("bot_upd", last_upd, 1);
    check("bot_sat_lo", sat_lo, 1);
    pulse(1'b0);
    check("clamp_lo_weight", last_w, 0);
    check("clamp_lo_upd", last_upd, 1);

    // Decrement edge during the busy window is dropped
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_weight", weight, 128);
    incr = 1'b1;
    step();
    decr = 1'b1;
    step();
    check("drop_k1_weight", weight, 132);
    check("drop_k1_upd", upd, 1);
    upd_seen = 0;
    repeat (10) begin
      step();
      if (upd) upd_seen++;
    end
    check("drop_weight", weight, 132);
    check("drop_no_upd", upd_seen, 0);
    incr = 1'b0;
    decr = 1'b0;
    step();

    // Reset during refractory aborts, then a fresh edge works
    incr = 1'b1;
    step();
    step();
    check("r5_weight", weight, 136);
    step();
    check("r5_busy", busy, 1);
    rst  = 1'b1;
    incr = 1'b0;
    step();
    rst = 1'b0;
    check("r5_rst_weight", weight, 128);
    check("r5_rst_busy", busy, 0);
    check("r5_rst_upd", upd, 0);
    step();
    incr = 1'b1;
    step();
    step();
    check("r5_new_weight", weight, 132);
    check("r5_new_upd", upd, 1);
    repeat (3) step();
    incr = 1'b0;
    step();
    check("r5_idle", busy, 0);

    // Simultaneous edges cancel
    incr = 1'b1;
    decr = 1'b1;
    step();
    check("both_busy", busy, 0);
    step();
    check("both_weight", weight, 132);
    check("both_upd", upd, 0);
    incr = 1'b0;
    decr = 1'b0;
    step();

    // Coincidence counter saturates and leaves the weight alone
    sim = 1'b1;
    step();
    check("sim_first", sim_cnt, 1);
    repeat (299) step();
    check("sim_sat", sim_cnt, 255);
    check("sim_weight", weight, 132);
    sim = 1'b0;
    step();
    check("sim_hold", sim_cnt, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
